// File: rtl/mips16_pkg.sv
// mips16_pkg: shared constants and types for the 16-bit MIPS datapath.
//   DATA_W / ADDR_W / NREGS  - register file geometry
//   PEND_W                   - width of the per-register pending-write counters
//   reg_addr_t / word_t      - register address and data word types
package mips16_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    localparam int PEND_W = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 4'd0;

    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

endpackage

// File: rtl/pend_counter.sv
// pend_counter: saturating up/down counter tracking outstanding writes to one
// register. Increments stop at PEND_MAX, decrements stop at zero, and a
// simultaneous effective inc/dec leaves the count unchanged.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-low reset, clears the count
//   inc    - request to add one outstanding write (ignored when saturated)
//   dec    - request to retire one outstanding write (ignored when zero)
//   cnt    - current count
//   sat    - count is at PEND_MAX
module pend_counter
    import mips16_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              sat
);

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic              inc_ok;
    logic              dec_ok;

    assign sat    = (cnt_q == PEND_MAX);
    assign inc_ok = inc && !sat;
    // A writeback to an untracked register (count 0) is legal and leaves it at 0.
    assign dec_ok = dec && (cnt_q != PEND_ZERO);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + PEND_ONE;
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - PEND_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= PEND_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: writeback-side register file with two combinational read
// ports, same-cycle write bypass and a per-register pending-write scoreboard.
// Ports:
//   clock, reset        - system clock, asynchronous active-low reset
//   IssueEn, IssueDest  - decode claims IssueDest as a pending destination
//   RegWrite, WrAddr,
//   WrData              - writeback strobe, destination and data
//   RdAddr1/2, RdData1/2- combinational read ports (r0 reads as zero)
//   Stall               - a read source still has an unresolved pending write
//   Overflow            - sticky: an issue hit a saturated pending counter
module reg_file_wb
    import mips16_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueDest,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [ADDR_W-1:0] RdAddr1,
    input  logic [ADDR_W-1:0] RdAddr2,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    output logic              Stall,
    output logic              Overflow
);

    word_t             regs_q [NREGS];
    logic [PEND_W-1:0] cnt_w  [NREGS];
    logic [NREGS-1:0]  sat_w;
    logic              ovf_q;
    logic              ovf_d;
    logic              wr_hit1;
    logic              wr_hit2;
    logic              pend1;
    logic              pend2;

    // r0 is never pending.
    assign cnt_w[0] = PEND_ZERO;
    assign sat_w[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_pend
        pend_counter u_pend_counter (
            .clock (clock),
            .reset (reset),
            .inc   (IssueEn  && (IssueDest == ADDR_W'(r))),
            .dec   (RegWrite && (WrAddr    == ADDR_W'(r))),
            .cnt   (cnt_w[r]),
            .sat   (sat_w[r])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWrite && (WrAddr != REG_ZERO)) begin
            regs_q[WrAddr] <= WrData;
        end
    end

    // The dropped issue still flags the error; the counter itself refuses it.
    always_comb begin
        ovf_d = ovf_q;
        if (IssueEn && (IssueDest != REG_ZERO) && sat_w[IssueDest]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Overflow = ovf_q;

    assign wr_hit1 = RegWrite && (WrAddr == RdAddr1);
    assign wr_hit2 = RegWrite && (WrAddr == RdAddr2);

    always_comb begin
        RdData1 = regs_q[RdAddr1];
        if (RdAddr1 == REG_ZERO) begin
            RdData1 = '0;
        end else if (wr_hit1) begin
            RdData1 = WrData;
        end
    end

    always_comb begin
        RdData2 = regs_q[RdAddr2];
        if (RdAddr2 == REG_ZERO) begin
            RdData2 = '0;
        end else if (wr_hit2) begin
            RdData2 = WrData;
        end
    end

    // The last outstanding write arriving this cycle is bypassed, so it does
    // not stall.
    assign pend1 = (RdAddr1 != REG_ZERO) && (cnt_w[RdAddr1] != PEND_ZERO)
                   && !(wr_hit1 && (cnt_w[RdAddr1] == PEND_ONE));
    assign pend2 = (RdAddr2 != REG_ZERO) && (cnt_w[RdAddr2] != PEND_ZERO)
                   && !(wr_hit2 && (cnt_w[RdAddr2] == PEND_ONE));

    assign Stall = pend1 | pend2;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;
    import mips16_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              IssueEn;
    logic [ADDR_W-1:0] IssueDest;
    logic              RegWrite;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic [ADDR_W-1:0] RdAddr1;
    logic [ADDR_W-1:0] RdAddr2;
    logic [DATA_W-1:0] RdData1;
    logic [DATA_W-1:0] RdData2;
    logic              Stall;
    logic              Overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain arrays of values and outstanding-write counts.
    int    cnt_m  [NREGS];
    word_t regs_m [NREGS];
    bit    ovf_m;

    always #5 clock = ~clock;

    reg_file_wb dut (
        .clock     (clock),
        .reset     (reset),
        .IssueEn   (IssueEn),
        .IssueDest (IssueDest),
        .RegWrite  (RegWrite),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .RdAddr1   (RdAddr1),
        .RdAddr2   (RdAddr2),
        .RdData1   (RdData1),
        .RdData2   (RdData2),
        .Stall     (Stall),
        .Overflow  (Overflow)
    );

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            cnt_m[i]  = 0;
            regs_m[i] = '0;
        end
        ovf_m = 0;
    endfunction

    // Apply the effect of one rising edge given the current inputs.
    function automatic void model_edge();
        int nc [NREGS];
        int d  = int'(IssueDest);
        int w  = int'(WrAddr);
        for (int r = 0; r < NREGS; r++) nc[r] = cnt_m[r];
        if (IssueEn && d != 0) begin
            if (cnt_m[d] >= 3) ovf_m = 1;
            else nc[d] = nc[d] + 1;
        end
        if (RegWrite && w != 0 && cnt_m[w] > 0) nc[w] = nc[w] - 1;
        for (int r = 0; r < NREGS; r++) cnt_m[r] = nc[r];
        if (RegWrite && w != 0) regs_m[w] = WrData;
    endfunction

    function automatic word_t exp_rd(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (RegWrite && WrAddr == a) return WrData;
        return regs_m[a];
    endfunction

    // A source stalls if writes will still be outstanding after this cycle's writeback.
    function automatic bit exp_pend(input logic [ADDR_W-1:0] a);
        int left;
        if (a == 0) return 0;
        left = cnt_m[a] - ((RegWrite && WrAddr == a) ? 1 : 0);
        return left > 0;
    endfunction

    task automatic idle();
        IssueEn   = 1'b0;
        IssueDest = '0;
        RegWrite  = 1'b0;
        WrAddr    = '0;
        WrData    = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        RdAddr1 = 4'd3;
        RdAddr2 = 4'd12;
        reset   = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (RdData1 !== 16'h0) begin n_err++; $display("FAIL reset_rd1 got=%h exp=0000", RdData1); end
        n_cmp++; if (RdData2 !== 16'h0) begin n_err++; $display("FAIL reset_rd2 got=%h exp=0000", RdData2); end
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        n_cmp++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (RdData1 !== 16'h0) begin n_err++; $display("FAIL post_reset_rd1 got=%h exp=0000", RdData1); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_r0();
        RegWrite = 1'b1; WrAddr = 4'd0; WrData = 16'hBEEF;
        RdAddr1  = 4'd0; RdAddr2 = 4'd0;
        #1;
        n_cmp++; if (RdData1 !== 16'h0000) begin n_err++; $display("FAIL r0_same_cycle got=%h exp=0000", RdData1); end
        tick();
        idle();
        #1;
        n_cmp++; if (RdData1 !== 16'h0000) begin n_err++; $display("FAIL r0_later got=%h exp=0000", RdData1); end
        n_cmp++; if (RdData2 !== 16'h0000) begin n_err++; $display("FAIL r0_later_p2 got=%h exp=0000", RdData2); end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WrAddr = 4'd3; WrData = 16'h1111;
        tick();
        RegWrite = 1'b1; WrAddr = 4'd3; WrData = 16'h2222;
        RdAddr1  = 4'd0; RdAddr2 = 4'd3;
        #1;
        n_cmp++; if (RdData2 !== 16'h2222) begin n_err++; $display("FAIL bypass_same got=%h exp=2222", RdData2); end
        tick();
        idle();
        #1;
        n_cmp++; if (RdData2 !== 16'h2222) begin n_err++; $display("FAIL bypass_next got=%h exp=2222", RdData2); end
    endtask

    task automatic test_issue_stall();
        RdAddr1 = 4'd7; RdAddr2 = 4'd0;
        IssueEn = 1'b1; IssueDest = 4'd7;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL issue_no_same_cycle_stall got=%b exp=0", Stall); end
        tick();
        idle();
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL issue_stall got=%b exp=1", Stall); end
        tick();
        RegWrite = 1'b1; WrAddr = 4'd7; WrData = 16'h00A5;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL wb_stall got=%b exp=0", Stall); end
        n_cmp++; if (RdData1 !== 16'h00A5) begin n_err++; $display("FAIL wb_bypass got=%h exp=00a5", RdData1); end
        tick();
        idle();
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL wb_cleared got=%b exp=0", Stall); end
        n_cmp++; if (RdData1 !== 16'h00A5) begin n_err++; $display("FAIL wb_stored got=%h exp=00a5", RdData1); end
    endtask

    task automatic test_simultaneous();
        RdAddr1 = 4'd4; RdAddr2 = 4'd0;
        IssueEn = 1'b1; IssueDest = 4'd4;
        tick();
        IssueEn  = 1'b1; IssueDest = 4'd4;
        RegWrite = 1'b1; WrAddr = 4'd4; WrData = 16'h4444;
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL simul_bypass_stall got=%b exp=0", Stall); end
        tick();
        idle();
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL simul_kept got=%b exp=1", Stall); end
        RegWrite = 1'b1; WrAddr = 4'd4; WrData = 16'h4545;
        tick();
        idle();
        #1;
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL simul_count_one got=%b exp=0", Stall); end
    endtask

    task automatic test_saturation();
        RdAddr1 = 4'd9; RdAddr2 = 4'd0;
        for (int i = 0; i < 4; i++) begin
            IssueEn = 1'b1; IssueDest = 4'd9;
            tick();
            idle();
            #1;
            n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL sat_stall[%0d] got=%b exp=1", i, Stall); end
            n_cmp++; if (Overflow !== (i == 3)) begin n_err++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", i, Overflow, (i == 3)); end
        end
        for (int i = 0; i < 3; i++) begin
            RegWrite = 1'b1; WrAddr = 4'd9; WrData = word_t'($urandom);
            tick();
            idle();
            #1;
            n_cmp++; if (Stall !== (i < 2)) begin n_err++; $display("FAIL drain_stall[%0d] got=%b exp=%b", i, Stall, (i < 2)); end
            n_cmp++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky[%0d] got=%b exp=1", i, Overflow); end
        end
    endtask

    task automatic test_mid_reset();
        RegWrite = 1'b1; WrAddr = 4'd5; WrData = 16'h1234;
        tick();
        for (int i = 0; i < 2; i++) begin
            idle();
            IssueEn = 1'b1; IssueDest = 4'd5;
            tick();
        end
        idle();
        RdAddr1 = 4'd5; RdAddr2 = 4'd0;
        #1;
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL pre_reset_stall got=%b exp=1", Stall); end
        n_cmp++; if (RdData1 !== 16'h1234) begin n_err++; $display("FAIL pre_reset_rd got=%h exp=1234", RdData1); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (RdData1 !== 16'h0) begin n_err++; $display("FAIL midrst_rd got=%h exp=0000", RdData1); end
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall got=%b exp=0", Stall); end
        n_cmp++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL midrst_ovf got=%b exp=0", Overflow); end
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (RdData1 !== 16'h0) begin n_err++; $display("FAIL after_rst_rd got=%h exp=0000", RdData1); end
        n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL after_rst_stall got=%b exp=0", Stall); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        for (int round = 0; round < 2; round++) begin
            for (int c = 0; c < 400; c++) begin
                IssueEn   = ($urandom_range(0, 1) == 1);
                IssueDest = ADDR_W'($urandom_range(0, NREGS - 1));
                RegWrite  = ($urandom_range(0, 1) == 1);
                WrAddr    = ADDR_W'($urandom_range(0, NREGS - 1));
                WrData    = word_t'($urandom);
                RdAddr1   = ADDR_W'($urandom_range(0, NREGS - 1));
                RdAddr2   = (c % 3 == 0) ? WrAddr : ADDR_W'($urandom_range(0, NREGS - 1));
                #1;
                n_cmp++; if (RdData1 !== exp_rd(RdAddr1)) begin n_err++; $display("FAIL rnd_rd1 cyc=%0d a=%0d got=%h exp=%h", c, RdAddr1, RdData1, exp_rd(RdAddr1)); end
                n_cmp++; if (RdData2 !== exp_rd(RdAddr2)) begin n_err++; $display("FAIL rnd_rd2 cyc=%0d a=%0d got=%h exp=%h", c, RdAddr2, RdData2, exp_rd(RdAddr2)); end
                n_cmp++; if (Stall !== (exp_pend(RdAddr1) | exp_pend(RdAddr2))) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, Stall, exp_pend(RdAddr1) | exp_pend(RdAddr2)); end
                n_cmp++; if (Overflow !== ovf_m) begin n_err++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, Overflow, ovf_m); end
                tick();
            end
            idle();
            reset = 1'b0;
            model_reset();
            @(negedge clock);
            #1 reset = 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_r0();
        test_bypass();
        test_issue_stall();
        test_simultaneous();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
